// File: rtl/pixel_stream_serializer_pkg.sv
// rtl/pixel_stream_serializer_pkg.sv - shared image geometry, pixel format and helpers
package pixel_stream_serializer_pkg;

  localparam int DEF_IMG_W       = 28;
  localparam int DEF_IMG_H       = 28;
  localparam int DEF_PIXEL_COUNT = DEF_IMG_W * DEF_IMG_H;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FRAC_BITS   = 8;

  // Number of bits needed to hold values 0 .. value-1
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/pixel_quantizer.sv
// rtl/pixel_quantizer.sv - signed fixed-point pixel to 8-bit grayscale quantizer
module pixel_quantizer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic signed [DATA_WIDTH-1:0] pixel,
  output logic        [7:0]            gray
);

  // +1.0 in the input Q format, one bit wider so the bias cannot overflow
  localparam logic signed [DATA_WIDTH:0] ONE = (DATA_WIDTH+1)'(1) << FRAC_BITS;

  logic signed [DATA_WIDTH:0] biased;
  logic signed [DATA_WIDTH:0] scaled;

  // Shift [-1,+1) up to [0,2), keep 8 integer-ish bits, then clamp to 0..255
  always_comb begin
    biased = $signed({pixel[DATA_WIDTH-1], pixel}) + ONE;
    scaled = biased >>> (FRAC_BITS - 7);
    if (scaled[DATA_WIDTH]) begin
      gray = 8'd0;
    end else if (|scaled[DATA_WIDTH-1:8]) begin
      gray = 8'hFF;
    end else begin
      gray = scaled[7:0];
    end
  end

endmodule

// File: rtl/pixel_stream_serializer.sv
// rtl/pixel_stream_serializer.sv - captures a pixel vector and streams it out quantized in raster order
module pixel_stream_serializer
  import pixel_stream_serializer_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  localparam int PIXEL_COUNT = IMG_W * IMG_H,
  localparam int ROW_W       = clog2(IMG_H),
  localparam int COL_W       = clog2(IMG_W),
  localparam int IDX_W       = clog2(PIXEL_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] vector_in,
  output logic [7:0]                        pix_data,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic                              pix_sof,
  output logic                              pix_eol,
  output logic                              pix_last,
  output logic [ROW_W-1:0]                  pix_row,
  output logic [COL_W-1:0]                  pix_col,
  output logic                              busy,
  output logic                              done
);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [DATA_WIDTH-1:0]  pix_buf [PIXEL_COUNT];
  logic [7:0]             gray;
  logic                   accept;
  logic                   handshake;
  logic                   at_last;
  logic                   at_eol;

  // Starts are only honoured in IDLE, so busy and FINISH cycles leave the buffer alone
  assign accept    = (state == ST_IDLE) && start;
  assign handshake = pix_valid && pix_ready;
  assign at_last   = (idx == IDX_W'(PIXEL_COUNT - 1));
  assign at_eol    = (pix_col == COL_W'(IMG_W - 1));

  // Capture the whole frame on an accepted start; it is held until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIXEL_COUNT; i++) begin
        pix_buf[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < PIXEL_COUNT; i++) begin
        pix_buf[i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  pixel_quantizer #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_quantizer (
    .pixel (pix_buf[idx]),
    .gray  (gray)
  );

  // Outputs are forced to zero whenever no pixel is being offered
  assign pix_data = pix_valid ? gray : 8'd0;
  assign pix_sof  = pix_valid && (idx == '0);
  assign pix_eol  = pix_valid && at_eol;
  assign pix_last = pix_valid && at_last;

  // Frame sequencer: counters advance only on a handshake so everything holds under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx       <= '0;
            pix_row   <= '0;
            pix_col   <= '0;
            pix_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            if (at_last) begin
              idx       <= '0;
              pix_row   <= '0;
              pix_col   <= '0;
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_FINISH;
            end else begin
              idx <= idx + IDX_W'(1);
              if (at_eol) begin
                pix_col <= '0;
                pix_row <= pix_row + ROW_W'(1);
              end else begin
                pix_col <= pix_col + COL_W'(1);
              end
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          pix_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// tb/tb_pixel_stream_serializer.sv - scoreboard bench for pixel_stream_serializer
module tb_pixel_stream_serializer;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int N  = W * H;
  localparam int DW = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       last;
    logic [4:0] row;
    logic [4:0] col;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DW*N-1:0]   vector_in;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_last;
  logic [4:0]        pix_row;
  logic [4:0]        pix_col;
  logic              busy;
  logic              done;

  exp_t              sb[$];
  int                frame[N];
  logic [7:0]        expd[N];
  logic [DW*N-1:0]   alt_vec;
  int                checks = 0;
  int                errors = 0;

  pixel_stream_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vector_in (vector_in),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_last  (pix_last),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_q(input int x);
    int s;
    s = (x + 256) >>> 1;
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  task automatic load_frame();
    for (int i = 0; i < N; i++) begin
      vector_in[i*DW +: DW] = 16'(frame[i]);
      expd[i] = model_q(frame[i]);
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(65535)) - 32768;
  endtask

  task automatic start_frame();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data = expd[i];
      e.sof  = (i == 0);
      e.eol  = ((i % W) == W - 1);
      e.last = (i == N - 1);
      e.row  = 5'(i / W);
      e.col  = 5'(i % W);
      sb.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({pix_valid, pix_sof, busy} !== 3'b111)
      $display("FAIL start_latency: valid/sof/busy=%b expected 111", {pix_valid, pix_sof, busy});
    if ({pix_valid, pix_sof, busy} !== 3'b111) errors++;
  endtask

  task automatic run_frame(input int duty, input int inject_at, input int abort_at);
    int   hs = 0;
    int   cyc = 0;
    bit   stall = 0;
    bit   fin = 0;
    bit   aborted = 0;
    bit   injected = 0;
    exp_t cur, snap, e;
    snap = '0;
    while (!fin) begin
      cur = {pix_data, pix_sof, pix_eol, pix_last, pix_row, pix_col};
      if (stall) begin
        checks++;
        if (cur !== snap || pix_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got %h valid=%b expected %h valid=1", cur, pix_valid, snap);
        end
      end
      if (start) start = 1'b0;
      if (hs == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({pix_valid, busy, done} !== 3'b000) begin
          errors++;
          $display("FAIL async_reset: valid/busy/done=%b expected 000", {pix_valid, busy, done});
        end
        sb.delete();
        fin = 1;
        aborted = 1;
      end else begin
        pix_ready = ($urandom_range(99) < duty);
        if (hs == inject_at && !injected) begin
          vector_in = alt_vec;
          start = 1'b1;
          injected = 1;
        end
        if (pix_valid && pix_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL extra_pixel: got %h expected none", cur);
          end else begin
            e = sb.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL pixel_%0d: got %h expected %h", hs, cur, e);
            end
          end
          hs++;
          if (cur.last) fin = 1;
        end
        stall = pix_valid && !pix_ready;
        snap = cur;
        @(negedge clk);
        cyc++;
        if (cyc > 20000) begin
          checks++;
          errors++;
          $display("FAIL timeout: handshakes %0d expected %0d", hs, N);
          fin = 1;
        end
      end
    end
    pix_ready = 1'b0;
    if (!aborted) begin
      checks++;
      if (hs !== N || sb.size() != 0) begin
        errors++;
        $display("FAIL handshake_count: got %0d left %0d expected %0d left 0", hs, sb.size(), N);
      end
      checks++;
      if ({done, busy, pix_valid} !== 3'b100) begin
        errors++;
        $display("FAIL done_pulse: done/busy/valid=%b expected 100", {done, busy, pix_valid});
      end
      if (duty >= 100) begin
        checks++;
        if (cyc !== N) begin
          errors++;
          $display("FAIL throughput: cycles %0d expected %0d", cyc, N);
        end
      end
    end
  endtask

  task automatic finish_idle();
    @(negedge clk);
    checks++;
    if ({done, busy, pix_valid} !== 3'b000) begin
      errors++;
      $display("FAIL done_width: done/busy/valid=%b expected 000", {done, busy, pix_valid});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({pix_data, pix_valid, pix_sof, pix_eol, pix_last, pix_row, pix_col, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0",
               {pix_data, pix_valid, pix_sof, pix_eol, pix_last, pix_row, pix_col, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int i = 0; i < N; i++) frame[i] = ((i - 392) * 2) / 3;
    load_frame();
    start_frame();
    run_frame(100, -1, -1);
    finish_idle();
  endtask

  task automatic test_saturation();
    random_frame();
    frame[0] = 32767;
    frame[1] = 256;
    frame[2] = 255;
    frame[3] = 0;
    frame[4] = -256;
    frame[5] = -32768;
    load_frame();
    expd[0] = 8'd255;
    expd[1] = 8'd255;
    expd[2] = 8'd255;
    expd[3] = 8'd128;
    expd[4] = 8'd0;
    expd[5] = 8'd0;
    start_frame();
    run_frame(100, -1, -1);
    finish_idle();
  endtask

  task automatic test_backpressure();
    random_frame();
    load_frame();
    start_frame();
    run_frame(30, -1, -1);
    finish_idle();
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < N; i++) alt_vec[i*DW +: DW] = 16'h7FFF;
    random_frame();
    load_frame();
    start_frame();
    run_frame(100, 100, -1);
    random_frame();
    load_frame();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({pix_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL start_on_done: valid/busy/done=%b expected 000", {pix_valid, busy, done});
    end
    start_frame();
    run_frame(100, -1, -1);
    finish_idle();
  endtask

  task automatic test_reset_mid();
    random_frame();
    load_frame();
    start_frame();
    run_frame(60, -1, 400);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({pix_valid, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_idle: valid/busy/done=%b expected 000", {pix_valid, busy, done});
      end
    end
    random_frame();
    load_frame();
    start_frame();
    checks++;
    if ({pix_row, pix_col} !== 10'd0) begin
      errors++;
      $display("FAIL restart_origin: row/col=%h expected 0", {pix_row, pix_col});
    end
    run_frame(100, -1, -1);
    finish_idle();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pix_ready = 1'b0;
    vector_in = '0;
    alt_vec   = '0;
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
